// File: rtl/mni_packetizer_vc.sv
// MNI packetizer with per-VC credit flow control: one request plus its write
// beats become head/body/tail flits tagged with the VC id.
module mni_vc_state #(
  parameter int CREDIT_DEPTH = 4,
  parameter int SN_WIDTH     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec,
  input  logic                inc,
  input  logic                acc,
  output logic [3:0]          credit,
  output logic [SN_WIDTH-1:0] sn,
  output logic                ovf
);
  localparam logic [3:0] CDEPTH = 4'(CREDIT_DEPTH);

  // A return pulse on a full counter is dropped, not wrapped.
  assign ovf = inc & ~dec & (credit == CDEPTH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      credit <= CDEPTH;
      sn     <= '0;
    end else begin
      if (dec && !inc)                           credit <= credit - 4'd1;
      else if (inc && !dec && credit != CDEPTH)  credit <= credit + 4'd1;
      if (acc) sn <= sn + 1'b1;
    end
  end
endmodule

module mni_packetizer_vc #(
  parameter int PAYLOAD_WIDTH = 32,
  parameter int XY_WIDTH      = 4,
  parameter int NUM_VC        = 2,
  parameter int VC_W          = 1,
  parameter int CREDIT_DEPTH  = 4,
  parameter int SN_WIDTH      = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [XY_WIDTH-1:0]             myx,
  input  logic [XY_WIDTH-1:0]             myy,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_rw,
  input  logic [3:0]                      req_len,
  input  logic [2*XY_WIDTH-1:0]           req_dest,
  input  logic [VC_W-1:0]                 req_vc,
  input  logic [PAYLOAD_WIDTH-1:0]        wdata,
  input  logic                            wdata_valid,
  output logic                            wdata_ready,
  output logic [2+VC_W+PAYLOAD_WIDTH-1:0] flit_out,
  output logic                            flit_valid,
  input  logic [NUM_VC-1:0]               credit_in,
  output logic                            busy,
  output logic                            credit_err
);
  localparam int HEAD_W = 4*XY_WIDTH + SN_WIDTH + 5;
  localparam int NVC2   = 1 << VC_W;

  localparam logic [1:0] T_HEAD = 2'b10, T_BODY = 2'b00, T_TAIL = 2'b01, T_HT = 2'b11;

  typedef enum logic {IDLE, DATA} state_t;
  state_t state, state_nxt;

  logic [VC_W-1:0]                 vc_q, cur_vc;
  logic [3:0]                      beat_cnt;
  logic [NVC2-1:0][3:0]            credit;
  logic [NVC2-1:0][SN_WIDTH-1:0]   sn;
  logic [NUM_VC-1:0]               dec, ovf;
  logic                            cred_ok, emit;
  logic [1:0]                      ftype;
  logic [PAYLOAD_WIDTH-1:0]        head_pl, payload;

  // VC ids beyond NUM_VC read as zero credits, so requests to them stall.
  genvar v;
  generate
    for (v = 0; v < NVC2; v++) begin : g_vc
      if (v < NUM_VC) begin : g_live
        assign dec[v] = emit & (cur_vc == VC_W'(v));
        mni_vc_state #(.CREDIT_DEPTH(CREDIT_DEPTH), .SN_WIDTH(SN_WIDTH)) u_vc (
          .clk(clk), .rst(rst), .dec(dec[v]), .inc(credit_in[v]),
          .acc(req_ready & (req_vc == VC_W'(v))),
          .credit(credit[v]), .sn(sn[v]), .ovf(ovf[v])
        );
      end else begin : g_dead
        assign credit[v] = '0;
        assign sn[v]     = '0;
      end
    end
  endgenerate

  assign cur_vc  = (state == IDLE) ? req_vc : vc_q;
  assign cred_ok = credit[cur_vc] != 4'd0;
  assign busy    = (state == DATA) | flit_valid;

  always_comb begin
    head_pl                = '0;
    head_pl[HEAD_W-1:0]    = {req_dest, myx, myy, sn[req_vc], req_rw, req_len};
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    emit        = 1'b0;
    ftype       = T_BODY;
    payload     = head_pl;
    case (state)
      IDLE: begin
        req_ready = req_valid & cred_ok;
        emit      = req_ready;
        ftype     = req_rw ? T_HEAD : T_HT;
        if (req_ready && req_rw) state_nxt = DATA;
      end
      DATA: begin
        wdata_ready = cred_ok;
        emit        = wdata_ready & wdata_valid;
        ftype       = (beat_cnt == 4'd0) ? T_TAIL : T_BODY;
        payload     = wdata;
        if (emit && beat_cnt == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vc_q       <= '0;
      beat_cnt   <= '0;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      flit_valid <= emit;
      if (emit) flit_out <= {ftype, cur_vc, payload};
      if (req_ready) begin
        vc_q     <= req_vc;
        beat_cnt <= req_len;
      end else if (state == DATA && emit && beat_cnt != 4'd0) begin
        beat_cnt <= beat_cnt - 4'd1;
      end
      if (|ovf) credit_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mni_packetizer_vc.sv
// Directed bench for mni_packetizer_vc; expected flits queue up at handshake
// time and a negedge monitor pops and compares them.
module tb_mni_packetizer_vc;
  localparam int PW = 32, XW = 4, NV = 2, VW = 1, CD = 4, SW = 5;
  localparam int FW = 2 + VW + PW;

  logic          clk, rst;
  logic [XW-1:0] myx, myy;
  logic          req_valid, req_ready, req_rw;
  logic [3:0]    req_len;
  logic [7:0]    req_dest;
  logic [VW-1:0] req_vc;
  logic [PW-1:0] wdata;
  logic          wdata_valid, wdata_ready;
  logic [FW-1:0] flit_out;
  logic          flit_valid, busy, credit_err;
  logic [NV-1:0] credit_in;

  mni_packetizer_vc #(.PAYLOAD_WIDTH(PW), .XY_WIDTH(XW), .NUM_VC(NV), .VC_W(VW),
                      .CREDIT_DEPTH(CD), .SN_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .myx(myx), .myy(myy),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_len(req_len), .req_dest(req_dest), .req_vc(req_vc),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .flit_out(flit_out), .flit_valid(flit_valid), .credit_in(credit_in),
    .busy(busy), .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [FW-1:0] sb[$];
  int            fcyc[$];
  int            n_total = 0, n_pass = 0;
  logic [SW-1:0] sn_m[NV];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [FW-1:0] head_f(input logic [1:0] t, input logic [VW-1:0] vc,
      input logic [7:0] dest, input logic [SW-1:0] s, input logic rw, input logic [3:0] len);
    logic [PW-1:0] p;
    p        = '0;
    p[25:0]  = {dest, myx, myy, s, rw, len};
    return {t, vc, p};
  endfunction

  always @(negedge clk) begin
    if (flit_valid === 1'b1) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check("flit", 64'(flit_out), 64'(sb.pop_front()));
      fcyc.push_back(cyc);
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send_req(input logic rw, input logic [3:0] len, input logic [7:0] dest,
                          input logic [VW-1:0] vc, input logic [NV-1:0] cmask, output logic took);
    req_valid = 1'b1; req_rw = rw; req_len = len; req_dest = dest; req_vc = vc;
    credit_in = cmask;
    @(negedge clk);
    took = req_ready;
    if (took) begin
      sb.push_back(head_f(rw ? 2'b10 : 2'b11, vc, dest, sn_m[vc], rw, len));
      sn_m[vc] = sn_m[vc] + 1'b1;
    end
    sync();
    req_valid = 1'b0; credit_in = '0;
  endtask

  task automatic try_beat(input logic [PW-1:0] d, input logic last, input logic [VW-1:0] vc,
                          input logic [NV-1:0] cmask, output logic took);
    wdata = d; wdata_valid = 1'b1; credit_in = cmask;
    @(negedge clk);
    took = wdata_ready;
    if (took) sb.push_back({last ? 2'b01 : 2'b00, vc, d});
    sync();
    wdata_valid = 1'b0; credit_in = '0;
  endtask

  task automatic pulse(input logic [NV-1:0] cmask);
    credit_in = cmask;
    sync();
    credit_in = '0;
  endtask

  initial begin
    logic took;
    int   n0;
    rst = 1'b0; myx = 4'd1; myy = 4'd2;
    req_valid = 0; req_rw = 0; req_len = 0; req_dest = 0; req_vc = 0;
    wdata = 0; wdata_valid = 0; credit_in = 0;
    for (int i = 0; i < NV; i++) sn_m[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flit_valid", 64'(flit_valid), 64'd0);
    check("rst_flit_out", 64'(flit_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_credit_err", 64'(credit_err), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_wdata_ready", 64'(wdata_ready), 64'd0);
    sync();
    rst = 1'b1;
    sync();

    // 1: single-flit reads, sn 0 then 1
    send_req(1'b0, 4'd0, 8'h30, 1'b0, 2'b00, took);
    check("t1_acc0", 64'(took), 64'd1);
    @(negedge clk);
    check("t1_valid", 64'(flit_valid), 64'd1);
    check("t1_flit0", 64'(flit_out), 64'({2'b11, 1'b0, 32'h00C0_4800}));
    check("t1_busy", 64'(busy), 64'd1);
    sync();
    @(negedge clk);
    check("t1_pulse", 64'(flit_valid), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);
    sync();
    send_req(1'b0, 4'd0, 8'h30, 1'b0, 2'b00, took);
    check("t1_acc1", 64'(took), 64'd1);
    @(negedge clk);
    check("t1_flit1", 64'(flit_out), 64'({2'b11, 1'b0, 32'h00C0_4820}));
    sync();

    // 2: 3-beat write on vc1, back-to-back flits
    n0 = fcyc.size();
    send_req(1'b1, 4'd2, 8'h12, 1'b1, 2'b00, took);
    check("t2_acc", 64'(took), 64'd1);
    try_beat(32'hA, 1'b0, 1'b1, 2'b00, took); check("t2_b0", 64'(took), 64'd1);
    try_beat(32'hB, 1'b0, 1'b1, 2'b00, took); check("t2_b1", 64'(took), 64'd1);
    try_beat(32'hC, 1'b1, 1'b1, 2'b00, took); check("t2_b2", 64'(took), 64'd1);
    repeat (2) sync();
    check("t2_nflits", 64'(fcyc.size() - n0), 64'd4);
    check("t2_b2b", 64'(fcyc[n0+3] - fcyc[n0]), 64'd3);
    send_req(1'b0, 4'd0, 8'h12, 1'b1, 2'b00, took);
    check("t2_vc1_empty", 64'(took), 64'd0);
    pulse(2'b01); pulse(2'b01);
    @(negedge clk);
    check("t2_no_err", 64'(credit_err), 64'd0);
    sync();

    // 3: write longer than credit window on vc0
    send_req(1'b1, 4'd5, 8'h21, 1'b0, 2'b00, took);
    check("t3_acc", 64'(took), 64'd1);
    for (int i = 0; i < 3; i++) begin
      try_beat(32'h100 + i, 1'b0, 1'b0, 2'b00, took);
      check("t3_beat", 64'(took), 64'd1);
    end
    try_beat(32'h103, 1'b0, 1'b0, 2'b00, took); check("t3_stall0", 64'(took), 64'd0);
    try_beat(32'h103, 1'b0, 1'b0, 2'b10, took); check("t3_stall1", 64'(took), 64'd0);
    try_beat(32'h103, 1'b0, 1'b0, 2'b00, took); check("t3_other_vc", 64'(took), 64'd0);
    try_beat(32'h103, 1'b0, 1'b0, 2'b01, took); check("t3_stall2", 64'(took), 64'd0);
    try_beat(32'h103, 1'b0, 1'b0, 2'b00, took); check("t3_resume0", 64'(took), 64'd1);
    try_beat(32'h104, 1'b0, 1'b0, 2'b01, took); check("t3_stall3", 64'(took), 64'd0);
    try_beat(32'h104, 1'b0, 1'b0, 2'b00, took); check("t3_resume1", 64'(took), 64'd1);

    // 4: simultaneous return + emission keeps count; overflow sets credit_err
    try_beat(32'h105, 1'b1, 1'b0, 2'b01, took); check("t4_stall", 64'(took), 64'd0);
    try_beat(32'h105, 1'b1, 1'b0, 2'b01, took); check("t4_tail", 64'(took), 64'd1);
    repeat (2) sync();
    send_req(1'b0, 4'd0, 8'h03, 1'b0, 2'b00, took); check("t4_cnt1", 64'(took), 64'd1);
    send_req(1'b0, 4'd0, 8'h03, 1'b0, 2'b00, took); check("t4_cnt0", 64'(took), 64'd0);
    repeat (4) pulse(2'b01);
    @(negedge clk);
    check("t4_full_no_err", 64'(credit_err), 64'd0);
    sync();
    pulse(2'b01);
    @(negedge clk);
    check("t4_err", 64'(credit_err), 64'd1);
    sync();
    for (int i = 0; i < CD; i++) begin
      send_req(1'b0, 4'd0, 8'h03, 1'b0, 2'b00, took);
      check("t4_full_acc", 64'(took), 64'd1);
    end
    send_req(1'b0, 4'd0, 8'h03, 1'b0, 2'b00, took); check("t4_cap", 64'(took), 64'd0);
    check("t4_err_sticky", 64'(credit_err), 64'd1);

    // 5: 32 back-to-back reads with per-cycle credit return; sn wraps
    pulse(2'b01);
    repeat (2) sync();
    n0 = fcyc.size();
    for (int i = 0; i < 32; i++) begin
      send_req(1'b0, 4'd1, 8'h44, 1'b0, 2'b01, took);
      check("t5_acc", 64'(took), 64'd1);
    end
    repeat (2) sync();
    check("t5_nflits", 64'(fcyc.size() - n0), 64'd32);
    check("t5_b2b", 64'(fcyc[n0+31] - fcyc[n0]), 64'd31);

    // 6: reset mid-packet
    repeat (3) pulse(2'b01);
    send_req(1'b1, 4'd3, 8'h55, 1'b0, 2'b00, took); check("t6_acc", 64'(took), 64'd1);
    try_beat(32'h600, 1'b0, 1'b0, 2'b00, took); check("t6_b0", 64'(took), 64'd1);
    try_beat(32'h601, 1'b0, 1'b0, 2'b00, took); check("t6_b1", 64'(took), 64'd1);
    rst = 1'b0;
    wdata_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_flit_valid", 64'(flit_valid), 64'd0);
    check("t6_flit_out", 64'(flit_out), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_credit_err", 64'(credit_err), 64'd0);
    check("t6_wdata_ready", 64'(wdata_ready), 64'd0);
    sync();
    wdata_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < NV; i++) sn_m[i] = '0;
    for (int i = 0; i < CD; i++) begin
      send_req(1'b0, 4'd0, 8'h30, 1'b0, 2'b00, took);
      check("t6_acc_after", 64'(took), 64'd1);
    end
    send_req(1'b0, 4'd0, 8'h30, 1'b0, 2'b00, took); check("t6_cap", 64'(took), 64'd0);
    send_req(1'b0, 4'd0, 8'h30, 1'b1, 2'b00, took); check("t6_vc1", 64'(took), 64'd1);

    repeat (3) sync();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mni_packetizer_vc.md
Name: mni_packetizer_vc

Overview:
- Parametrised, credit-flow-controlled packetizer for the master network interface (MNI) path.
- Sits between the MNI controller's transaction request/data side and the router link, and is the successor of the single-channel PACK stage.
- Adds NUM_VC virtual channels, per-VC credit counters, per-VC sequence numbers and single-flit read-request packets.
- Converts one transaction request plus its write beats into head/body/tail flits tagged with the VC id.

Parameters:
- PAYLOAD_WIDTH, 32, flit payload bits.
- XY_WIDTH, 4, width of each X/Y coordinate.
- NUM_VC, 2, number of virtual channels (1..4).
- VC_W, 1, VC id width; must satisfy 2^VC_W >= NUM_VC.
- CREDIT_DEPTH, 4, downstream buffer slots per VC (1..15).
- SN_WIDTH, 5, per-VC sequence number width.
- Legal sizing: 4*XY_WIDTH + SN_WIDTH + 5 <= PAYLOAD_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- myx  in  XY_WIDTH  local X coordinate.
- myy  in  XY_WIDTH  local Y coordinate.
- req_valid  in  1  transaction request valid.
- req_ready  out  1  request accepted this cycle (combinational).
- req_rw  in  1  1 = write, 0 = read.
- req_len  in  4  beats-1.
- req_dest  in  2*XY_WIDTH  destination {x,y}.
- req_vc  in  VC_W  target VC.
- wdata  in  PAYLOAD_WIDTH  write beat.
- wdata_valid  in  1  write beat valid.
- wdata_ready  out  1  write beat accepted (combinational).
- flit_out  out  2+VC_W+PAYLOAD_WIDTH  {type, vc, payload}, registered.
- flit_valid  out  1  one-cycle pulse per flit.
- credit_in  in  NUM_VC  one-cycle credit-return pulse per VC.
- busy  out  1  packet in progress.
- credit_err  out  1  sticky credit-overflow flag.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-low.
- Reset values: all outputs 0; credit[v] = CREDIT_DEPTH; sn[v] = 0; FSM = IDLE.
- Reset asserted mid-packet aborts the packet with no tail emitted. The downstream side is reset together with this block.
- Flit types:
  - HEAD = 2'b10
  - BODY = 2'b00
  - TAIL = 2'b01
  - HEADTAIL = 2'b11
- Head payload, MSB to LSB: zero pad, req_dest, {myx,myy}, sn[vc], req_rw, req_len.
- Body/tail payload = wdata.
- FSM states: IDLE, DATA.
- IDLE:
  - req_ready = req_valid & (credit[req_vc] != 0).
  - On acceptance, latch rw, len, vc and dest, and register the head flit. flit_valid is high the next cycle (latency 1).
  - Read (req_rw=0): flit type is HEADTAIL and the FSM stays IDLE. A new request can be accepted in the very next cycle.
  - Write: flit type is HEAD; load beat_cnt = len; go to DATA.
  - sn[vc] increments by 1 on every accepted request, wrapping modulo 2^SN_WIDTH.
- DATA:
  - wdata_ready = credit[vc] != 0; req_ready = 0.
  - Each accepted beat registers one flit.
  - The beat with beat_cnt == 0 is TAIL, and the FSM returns to IDLE. All other beats are BODY, and beat_cnt decrements.
  - A write of N beats emits exactly N+1 flits.
- flit_valid is high only in the cycle after a flit is registered. flit_out holds its last value otherwise.
- Credit counters:
  - Decrement on a flit registered on VC v.
  - Increment on credit_in[v].
  - Both in the same cycle: counter unchanged.
  - credit_in[v] when credit[v] == CREDIT_DEPTH with no same-cycle decrement: ignored, and credit_err is set. credit_err clears only on reset.
  - A counter never reaches below 0, because emission is gated by the credit != 0 check.
- Credit stall: a flit is never emitted on a VC whose counter is 0. Requests and beats are held off through req_ready / wdata_ready. Credits returned on other VCs do not unblock the stalled packet.
- Packets are never interleaved: one packet in flight at a time, regardless of VC.
- busy = (state == DATA) | flit_valid.
- Inputs wdata_valid in IDLE and req_valid in DATA are ignored.

Test Plan:
1. Reset, myx=1, myy=2, read req dest {3,0} vc0 len 0 → next cycle exactly one flit, type 11, vc 0, sn field 0. credit[0] goes 4→3. A second read gives sn 1.
2. Write len=2 on vc1 with continuous wdata 0xA,0xB,0xC → 4 consecutive flit_valid pulses with types 10,00,00,01, payloads head,0xA,0xB,0xC. credit[1]=0, credit[0]=4.
3. CREDIT_DEPTH=4, write len=5 on vc0, no credit_in → exactly 4 flits then stall with wdata_ready=0. Pulse credit_in[0] twice → 2 more flits. Pulse credit_in[1] → no effect on vc0.
4. Simultaneous credit_in[0] and vc0 flit emission → counter unchanged. credit_in[0] at count 4 while idle → credit_err=1 and count stays 4.
5. 32 reads on vc0 with credits replenished each cycle → sn wraps 31→0 and flits are back-to-back every cycle.
6. rst=0 during DATA after 2 of 4 beats → next cycle all outputs 0, credits back to CREDIT_DEPTH, FSM IDLE. A new read is accepted normally with sn 0.
